r5p_degu_ifq: RTL

//  Instruction fetch queue between the instruction bus (TCB manager side) and the Degu decode stage.

---
 rtl/r5p_degu_ifq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/r5p_degu_ifq.sv
// Degu instruction fetch queue: prefetches aligned words from the fetch bus and presents one instruction per cycle.
// Define R5P_IFQ_RVC_EN for the halfword queue with 16/32-bit realignment; otherwise the queue is word-granular.
module r5p_degu_ifq #(
    parameter int unsigned    ABW   = 32,
    parameter int unsigned    DEPTH = 4,
    parameter logic [ABW-1:0] PC0   = '0
)(
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           red_vld_i,
    input  logic [ABW-1:0] red_adr_i,
    output logic           mem_vld_o,
    output logic [ABW-1:0] mem_adr_o,
    input  logic           mem_rdy_i,
    input  logic [31:0]    mem_rdt_i,
    input  logic           mem_err_i,
    output logic           ins_vld_o,
    input  logic           ins_rdy_i,
    output logic [ABW-1:0] ins_pc_o,
    output logic [31:0]    ins_rdt_o,
    output logic [2:0]     ins_siz_o,
    output logic           ins_err_o
);

`ifdef R5P_IFQ_RVC_EN
    localparam int unsigned    ENT    = 2*DEPTH;
    localparam int unsigned    DW     = 16;
    localparam logic [ABW-1:0] PC_MSK = ~ABW'(1);
`else
    localparam int unsigned    ENT    = DEPTH;
    localparam int unsigned    DW     = 32;
    localparam logic [ABW-1:0] PC_MSK = ~ABW'(3);
`endif
    localparam int unsigned    AW     = $clog2(ENT);
    localparam logic [AW+1:0]  WPE    = (AW+2)'(ENT / DEPTH);
    localparam logic [AW+1:0]  LIM    = (AW+2)'(ENT);

    logic [DW-1:0]  dat_q [ENT];
    logic [ENT-1:0] err_q;

    logic [AW:0]    wr_q, wr_d, rd_q, rd_d;
    logic [ABW-1:0] adr_q, adr_d, pc_q, pc_d;
    logic           run_q, out_q, kill_q;
    logic [AW:0]    cnt, wr_inc, rd_inc;
    logic [AW+1:0]  need;
    logic [AW-1:0]  wa0, ra0;
    logic           trn, rsp, hsk;

    assign cnt  = wr_q - rd_q;
    assign need = {1'b0, cnt} + (out_q ? WPE : '0) + WPE;
    assign trn  = mem_vld_o & mem_rdy_i;
    // A response is dropped when its transfer coincided with a redirect, or a redirect arrives with it.
    assign rsp  = out_q & ~kill_q & ~red_vld_i;
    assign hsk  = ins_vld_o & ins_rdy_i;
    assign wa0  = wr_q[AW-1:0];
    assign ra0  = rd_q[AW-1:0];

    assign mem_vld_o = run_q & (need <= LIM);
    assign mem_adr_o = adr_q;
    assign ins_pc_o  = pc_q;

`ifdef R5P_IFQ_RVC_EN
    logic          skip_q, skip_d;
    logic [AW-1:0] wa1, ra1;
    logic          siz4;

    assign wa1       = wa0 + AW'(1);
    assign ra1       = ra0 + AW'(1);
    assign siz4      = &dat_q[ra0][1:0];
    assign ins_siz_o = siz4 ? 3'd4 : 3'd2;
    assign ins_vld_o = siz4 ? (cnt >= (AW+1)'(2)) : (cnt >= (AW+1)'(1));
    assign ins_rdt_o = {dat_q[ra1], dat_q[ra0]};
    assign ins_err_o = err_q[ra0] | (siz4 & err_q[ra1]);
    assign wr_inc    = skip_q ? (AW+1)'(1) : (AW+1)'(2);
    assign rd_inc    = siz4   ? (AW+1)'(2) : (AW+1)'(1);

    always_ff @(posedge clk_i) begin
        if (rsp) begin
            if (skip_q) begin
                dat_q[wa0] <= mem_rdt_i[31:16];
                err_q[wa0] <= mem_err_i;
            end else begin
                dat_q[wa0] <= mem_rdt_i[15:0];
                dat_q[wa1] <= mem_rdt_i[31:16];
                err_q[wa0] <= mem_err_i;
                err_q[wa1] <= mem_err_i;
            end
        end
    end
`else
    assign ins_siz_o = 3'd4;
    assign ins_vld_o = (cnt != '0);
    assign ins_rdt_o = dat_q[ra0];
    assign ins_err_o = err_q[ra0];
    assign wr_inc    = (AW+1)'(1);
    assign rd_inc    = (AW+1)'(1);

    always_ff @(posedge clk_i) begin
        if (rsp) begin
            dat_q[wa0] <= mem_rdt_i;
            err_q[wa0] <= mem_err_i;
        end
    end
`endif

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        adr_d = adr_q;
        pc_d  = pc_q;
`ifdef R5P_IFQ_RVC_EN
        skip_d = skip_q;
`endif
        if (red_vld_i) begin
            wr_d  = '0;
            rd_d  = '0;
            adr_d = red_adr_i & ~ABW'(3);
            pc_d  = red_adr_i & PC_MSK;
`ifdef R5P_IFQ_RVC_EN
            skip_d = red_adr_i[1];
`endif
        end else begin
            if (trn) adr_d = adr_q + ABW'(4);
            if (rsp) begin
                wr_d = wr_q + wr_inc;
`ifdef R5P_IFQ_RVC_EN
                skip_d = 1'b0;
`endif
            end
            if (hsk) begin
                rd_d = rd_q + rd_inc;
                pc_d = pc_q + ABW'(ins_siz_o);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q  <= 1'b0;
            out_q  <= 1'b0;
            kill_q <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            adr_q  <= PC0 & ~ABW'(3);
            pc_q   <= PC0;
`ifdef R5P_IFQ_RVC_EN
            skip_q <= PC0[1];
`endif
        end else begin
            run_q  <= 1'b1;
            out_q  <= trn;
            kill_q <= red_vld_i & trn;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            adr_q  <= adr_d;
            pc_q   <= pc_d;
`ifdef R5P_IFQ_RVC_EN
            skip_q <= skip_d;
`endif
        end
    end

endmodule
